// File: rtl/round_sat_out.sv
// round_sat_out: rounds a 25-bit signed sample by an arithmetic right shift
// (round-half-up), saturates it to 16-bit signed, and counts saturation events.
// A sample accepted at edge k reaches data_out at edge k+2. The pipeline is:
// stage 1 (round + shift), stage 2 (clamp decision), then the output register.
module round_sat_out #(
  parameter int SHIFT = 9,
  parameter bit SYM   = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [24:0] data_in,
  input  logic        sat_clr,
  output logic        out_valid,
  output logic [15:0] data_out,
  output logic        sat_flag,
  output logic [15:0] sat_cnt
);

  // Half an LSB of the shifted result. Shifting up then down by one gives 0
  // for SHIFT=0, so no special case is needed.
  localparam logic signed [25:0] ROUND_OFS = (26'sd1 <<< SHIFT) >>> 1;
  localparam logic signed [25:0] SAT_MAX   = 26'sd32767;
  localparam logic signed [25:0] SAT_MIN   = SYM ? -26'sd32767 : -26'sd32768;

  // The input is sign-extended by one bit, so adding the offset cannot overflow.
  logic signed [25:0] w_ext;
  logic signed [25:0] w_sum;
  logic signed [25:0] w_shr;

  assign w_ext = $signed({data_in[24], data_in});
  assign w_sum = w_ext + ROUND_OFS;
  assign w_shr = w_sum >>> SHIFT;

  // Stage 1 registers
  logic signed [25:0] r_s1_val;
  logic               r_s1_vld;

  // Stage 1: capture the rounded, shifted value for valid samples only
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_val <= '0;
      r_s1_vld <= 1'b0;
    end else begin
      r_s1_vld <= in_valid;
      if (in_valid) begin
        r_s1_val <= w_shr;
      end
    end
  end

  // Clamp decision on the stage-1 value
  logic        w_hi;
  logic        w_lo;
  logic [15:0] w_clamp;

  assign w_hi    = (r_s1_val > SAT_MAX);
  assign w_lo    = (r_s1_val < SAT_MIN);
  assign w_clamp = w_hi ? SAT_MAX[15:0] :
                   w_lo ? SAT_MIN[15:0] :
                          r_s1_val[15:0];

  // Stage 2 registers
  logic [15:0] r_s2_val;
  logic        r_s2_sat;
  logic        r_s2_vld;

  // Stage 2: register the clamped value and whether a clamp happened.
  // The compare is kept off the output register path.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s2_val <= '0;
      r_s2_sat <= 1'b0;
      r_s2_vld <= 1'b0;
    end else begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_val <= w_clamp;
        r_s2_sat <= w_hi | w_lo;
      end
    end
  end

  // r_s2_sat holds a stale value across gaps, so it is qualified by the valid bit
  logic w_event;
  assign w_event = r_s2_vld & r_s2_sat;

  // Output registers
  logic        r_out_valid;
  logic [15:0] r_data_out;
  logic        r_sat_flag;
  logic [15:0] r_sat_cnt;

  // Output stage: present valid samples and hold data_out across gaps
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_data_out  <= '0;
    end else begin
      r_out_valid <= r_s2_vld;
      if (r_s2_vld) begin
        r_data_out <= r_s2_val;
      end
    end
  end

  // Saturation bookkeeping: a clear in the same cycle as an event counts the
  // event after the clear; the counter sticks at all-ones
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sat_flag <= 1'b0;
      r_sat_cnt  <= '0;
    end else if (w_event) begin
      r_sat_flag <= 1'b1;
      if (sat_clr) begin
        r_sat_cnt <= 16'd1;
      end else if (r_sat_cnt != 16'hFFFF) begin
        r_sat_cnt <= r_sat_cnt + 16'd1;
      end
    end else if (sat_clr) begin
      r_sat_flag <= 1'b0;
      r_sat_cnt  <= '0;
    end
  end

  assign out_valid = r_out_valid;
  assign data_out  = r_data_out;
  assign sat_flag  = r_sat_flag;
  assign sat_cnt   = r_sat_cnt;

endmodule

// File: tb/tb_round_sat_out.sv
// tb_round_sat_out: drives one shared stimulus stream into three instances:
// u_a with SHIFT=9 and SYM=0, u_b with SHIFT=9 and SYM=1, and u_c with SHIFT=0
// and SYM=0. When a sample is driven, its expected result is pushed to a
// scoreboard together with the cycle in which it must appear.
module tb_round_sat_out;

  logic        clk      = 1'b0;
  logic        reset    = 1'b1;
  logic        in_valid = 1'b0;
  logic [24:0] data_in  = '0;
  logic        sat_clr  = 1'b0;

  logic        ov   [3];
  logic [15:0] dout [3];
  logic        fl   [3];
  logic [15:0] cn   [3];

  round_sat_out #(.SHIFT(9), .SYM(1'b0)) u_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .data_in(data_in), .sat_clr(sat_clr),
    .out_valid(ov[0]), .data_out(dout[0]), .sat_flag(fl[0]), .sat_cnt(cn[0]));
  round_sat_out #(.SHIFT(9), .SYM(1'b1)) u_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .data_in(data_in), .sat_clr(sat_clr),
    .out_valid(ov[1]), .data_out(dout[1]), .sat_flag(fl[1]), .sat_cnt(cn[1]));
  round_sat_out #(.SHIFT(0), .SYM(1'b0)) u_c (
    .clk(clk), .reset(reset), .in_valid(in_valid), .data_in(data_in), .sat_clr(sat_clr),
    .out_valid(ov[2]), .data_out(dout[2]), .sat_flag(fl[2]), .sat_cnt(cn[2]));

  always #5 clk = ~clk;

  typedef struct packed {
    int              due;
    logic [2:0][15:0] d;
    logic [2:0]       s;
  } sb_t;

  sb_t sbq[$];

  int   cyc   = 0;
  logic rst_e = 1'b1;
  logic clr_e = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [15:0] exp_cnt  [3];
  logic [15:0] exp_last [3];
  logic        exp_flag [3];

  // Count edges and capture the control inputs that applied at each edge.
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_e <= reset;
    clr_e <= sat_clr;
  end

  task automatic check(input string tag, input int inst, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s inst%0d cyc=%0d observed=%0h expected=%0h", tag, inst, cyc, obs, exp);
    end
  endtask

  // Reference result: add half an LSB, floor-divide by 2^sh, then clamp.
  function automatic void model(input logic [24:0] din, input int sh, input bit sym,
                                output logic [15:0] d, output bit s);
    longint v, p, q, lo;
    v = longint'($signed(din));
    p = longint'(1) << sh;
    if (sh > 0) v = v + p / 2;
    q = v / p;
    if (v < 0 && q * p != v) q = q - 1;
    lo = sym ? -32767 : -32768;
    if (q > 32767) begin
      d = 16'h7FFF; s = 1'b1;
    end else if (q < lo) begin
      d = lo[15:0]; s = 1'b1;
    end else begin
      d = q[15:0]; s = 1'b0;
    end
  endfunction

  // Drive one cycle. A valid sample accepted at edge cyc+1 is due at edge cyc+3.
  task automatic step(input bit v, input logic [24:0] d, input bit clr, input bit rst);
    sb_t e;
    logic [15:0] d0, d1, d2;
    bit s0, s1, s2;
    @(posedge clk);
    #1;
    reset    = rst;
    in_valid = v;
    data_in  = d;
    sat_clr  = clr;
    if (v && !rst) begin
      model(d, 9, 1'b0, d0, s0);
      model(d, 9, 1'b1, d1, s1);
      model(d, 0, 1'b0, d2, s2);
      e.due  = cyc + 3;
      e.d[0] = d0; e.d[1] = d1; e.d[2] = d2;
      e.s[0] = s0; e.s[1] = s1; e.s[2] = s2;
      sbq.push_back(e);
    end
  endtask

  // Scoreboard: compare every output on each falling edge.
  always @(negedge clk) begin
    sb_t e;
    bit  has;
    has = 1'b0;
    e   = '0;
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      has = 1'b1;
      e   = sbq[0];
    end
    for (int i = 0; i < 3; i++) begin
      if (rst_e) begin
        exp_cnt[i]  = '0;
        exp_flag[i] = 1'b0;
        exp_last[i] = '0;
      end else begin
        if (clr_e) begin
          exp_cnt[i]  = '0;
          exp_flag[i] = 1'b0;
        end
        if (has) begin
          exp_last[i] = e.d[i];
          if (e.s[i]) begin
            exp_flag[i] = 1'b1;
            if (exp_cnt[i] != 16'hFFFF) exp_cnt[i] = exp_cnt[i] + 16'd1;
          end
        end
      end
      check("out_valid", i, {31'd0, ov[i]}, {31'd0, (has && !rst_e)});
      check("data_out", i, {16'd0, dout[i]}, {16'd0, exp_last[i]});
      check("sat_flag", i, {31'd0, fl[i]}, {31'd0, exp_flag[i]});
      check("sat_cnt", i, {16'd0, cn[i]}, {16'd0, exp_cnt[i]});
    end
    if (rst_e) sbq.delete();
    else if (has) void'(sbq.pop_front());
  end

  initial begin
    // Reset, then idle cycles to observe the reset state
    step(0, 25'd0, 0, 1);
    step(0, 25'd0, 0, 1);
    step(0, 25'd0, 0, 0);
    step(0, 25'd0, 0, 0);

    // Rounding: ties toward +infinity
    step(1, 25'd512, 0, 0);
    step(1, 25'd255, 0, 0);
    step(1, 25'd256, 0, 0);
    step(1, -25'sd256, 0, 0);
    step(1, -25'sd257, 0, 0);
    repeat (3) step(0, 25'd0, 0, 0);

    // Saturation boundaries
    step(1, 25'h0FFFFFF, 0, 0);
    step(1, 25'h1000000, 0, 0);
    repeat (3) step(0, 25'd0, 0, 0);

    // Clear alone, then valid gaps 1,0,1,1,0 with data held during the gaps
    step(0, 25'd0, 1, 0);
    step(1, 25'd1000, 0, 0);
    step(0, 25'd12345, 0, 0);
    step(1, 25'd5000, 0, 0);
    step(1, -25'sd7000, 0, 0);
    step(0, 25'd777, 0, 0);
    repeat (4) step(0, 25'd0, 0, 0);

    // Counter saturation at 0xFFFF
    for (int n = 0; n < 65540; n++) step(1, 25'h0FFFFFF, 0, 0);
    repeat (3) step(0, 25'd0, 0, 0);

    // Clear alone, then clear coinciding with a saturating output
    step(0, 25'd0, 1, 0);
    step(0, 25'd0, 0, 0);
    step(1, 25'h0FFFFFF, 0, 0);
    step(0, 25'd0, 0, 0);
    step(0, 25'd0, 1, 0);
    repeat (3) step(0, 25'd0, 0, 0);

    // Reset mid-stream with two samples in flight, then a new sample
    step(1, 25'd100, 0, 0);
    step(1, 25'd200, 0, 0);
    step(0, 25'd0, 0, 1);
    step(0, 25'd0, 0, 0);
    step(1, 25'd100000, 0, 0);
    repeat (4) step(0, 25'd0, 0, 0);

    // SHIFT=0 cases (u_c), also run through the other instances
    step(1, 25'd40000, 0, 0);
    step(1, -25'sd5, 0, 0);
    repeat (4) step(0, 25'd0, 0, 0);

    @(negedge clk);
    check("sb_drained", 0, sbq.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
